// File: rtl/counter_seq_ctrl_pkg.sv
// Shared types for the step-counter sequencer.
// Optional build macro: COUNTER_SEQ_CTRL_WRAP_EN (shortest modular path).
package counter_seq_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE,
    RUN,
    HOLD,
    DONE
  } state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/counter_seq_ctrl_if.sv
// Request/status bundle between a command source and the sequencer.
// Optional build macro: COUNTER_SEQ_CTRL_WRAP_EN (no effect on this file).
interface counter_seq_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_target;
  logic             abort;
  logic             up;
  logic [WIDTH-1:0] dout;
  logic             busy;
  logic             done;

  modport master (
    output req_valid, req_target, abort,
    input  req_ready, up, dout, busy, done
  );

  modport slave (
    input  req_valid, req_target, abort,
    output req_ready, up, dout, busy, done
  );
endinterface

// File: rtl/counter_seq_ctrl_step_counter.sv
// WIDTH-bit up/down counter; steps by one only when en is high.
// Optional build macro: COUNTER_SEQ_CTRL_WRAP_EN (no effect on this file).
module step_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout <= '0;
    end else if (en) begin
      dout <= up ? dout + WIDTH'(1) : dout - WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Sequences a step counter to a requested target, holds, then pulses done.
// Optional build macro: COUNTER_SEQ_CTRL_WRAP_EN (shortest modular path).
module counter_seq_ctrl
  import counter_seq_ctrl_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int DIV      = 1,
  parameter int HOLD_CYC = 2
) (
  input logic               clk,
  input logic               rst,
  counter_seq_ctrl_if.slave bus
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

  state_t           state, state_nx;
  logic [PW-1:0]    pre, pre_nx;
  logic [HW-1:0]    hold, hold_nx;
  logic [WIDTH-1:0] target;
  logic             up_q, up_nx;
  logic             en;
  logic             hs;
  logic             dir_req;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_step;

  assign hs = bus.req_valid && (state == IDLE);

`ifdef COUNTER_SEQ_CTRL_WRAP_EN
  logic [WIDTH-1:0] du;
  logic [WIDTH-1:0] dd;
  assign du = bus.req_target - cnt;
  assign dd = cnt - bus.req_target;
  // ties go up
  assign dir_req = (du <= dd) ? DIR_UP : DIR_DN;
`else
  assign dir_req = (bus.req_target > cnt) ? DIR_UP : DIR_DN;
`endif

  assign cnt_step = up_q ? cnt + WIDTH'(1) : cnt - WIDTH'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      pre    <= '0;
      hold   <= '0;
      up_q   <= DIR_DN;
      target <= '0;
    end else begin
      state <= state_nx;
      pre   <= pre_nx;
      hold  <= hold_nx;
      up_q  <= up_nx;
      if (hs) begin
        target <= bus.req_target;
      end
    end
  end

  always_comb begin
    state_nx = state;
    pre_nx   = pre;
    hold_nx  = hold;
    up_nx    = up_q;
    en       = 1'b0;
    unique case (state)
      IDLE: begin
        if (hs) begin
          up_nx    = dir_req;
          pre_nx   = '0;
          hold_nx  = '0;
          state_nx = (bus.req_target == cnt) ? HOLD : RUN;
        end
      end
      RUN: begin
        // abort beats a final step
        if (bus.abort) begin
          state_nx = IDLE;
        end else if (pre == PRE_LAST) begin
          en     = 1'b1;
          pre_nx = '0;
          if (cnt_step == target) begin
            state_nx = HOLD;
            hold_nx  = '0;
          end
        end else begin
          pre_nx = pre + PW'(1);
        end
      end
      HOLD: begin
        if (bus.abort) begin
          state_nx = IDLE;
        end else if (hold == HOLD_LAST) begin
          state_nx = DONE;
        end else begin
          hold_nx = hold + HW'(1);
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  step_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .up  (up_q),
    .dout(cnt)
  );

  assign bus.req_ready = (state == IDLE);
  assign bus.busy      = (state == RUN) || (state == HOLD);
  assign bus.done      = (state == DONE);
  assign bus.up        = up_q;
  assign bus.dout      = cnt;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Scoreboard bench for counter_seq_ctrl (WIDTH=4, DIV=2, HOLD_CYC=2).
// Expectations follow COUNTER_SEQ_CTRL_WRAP_EN when it is defined.
module tb_counter_seq_ctrl;

  localparam int W   = 4;
  localparam int DIV = 2;
  localparam int HC  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  counter_seq_ctrl_if #(.WIDTH(W)) bus ();

  counter_seq_ctrl #(
    .WIDTH   (W),
    .DIV     (DIV),
    .HOLD_CYC(HC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit         is_done;
    logic [W-1:0] val;
    int         cyc;
  } ev_t;

  ev_t q[$];
  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;
  logic [W-1:0] prev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic take_ev(bit d, logic [W-1:0] v);
    ev_t e;
    n_chk++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got done=%0d val=%0d cyc=%0d expected none",
               d, v, cyc);
    end else begin
      e = q.pop_front();
      if (e.is_done !== d || e.val !== v || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL event: got done=%0d val=%0d cyc=%0d expected done=%0d val=%0d cyc=%0d",
                 d, v, cyc, e.is_done, e.val, e.cyc);
      end
    end
  endtask

  // monitor: every dout change and every done cycle is an event
  always @(negedge clk) begin
    if (!rst) begin
      prev = bus.dout;
    end else begin
      if (bus.dout !== prev) take_ev(1'b0, bus.dout);
      if (bus.done === 1'b1) take_ev(1'b1, bus.dout);
      prev = bus.dout;
    end
  end

  task automatic run_req(input logic [W-1:0] tgt, input logic [W-1:0] start,
                         input int d, input bit up_exp, input int upto);
    ev_t e;
    int n;
    @(negedge clk);
    chk("req_ready_idle", bus.req_ready, 1);
    bus.req_valid  = 1'b1;
    bus.req_target = tgt;
    n = cyc + 1;
    for (int i = 1; i <= upto; i++) begin
      e.is_done = 1'b0;
      e.val     = up_exp ? start + W'(i) : start - W'(i);
      e.cyc     = n + i * DIV;
      q.push_back(e);
    end
    if (upto == d) begin
      e.is_done = 1'b1;
      e.val     = tgt;
      e.cyc     = n + d * DIV + HC;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("up_dir", bus.up, up_exp);
    chk("busy_after_hs", bus.busy, 1);
    chk("req_ready_busy", bus.req_ready, 0);
  endtask

  task automatic wait_idle(string name);
    int k = 0;
    while (q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({"finish_", name}, q.size() == 0, 1);
    @(negedge clk);
  endtask

  initial begin
    int k;
    bus.req_valid  = 1'b0;
    bus.req_target = '0;
    bus.abort      = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_dout", bus.dout, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_up", bus.up, 0);
    rst = 1'b1;

    run_req(4'd5, 4'd0, 5, 1'b1, 5);
    wait_idle("t1_0to5");
    run_req(4'd1, 4'd5, 4, 1'b0, 4);
    wait_idle("5to1");
`ifdef COUNTER_SEQ_CTRL_WRAP_EN
    run_req(4'd14, 4'd1, 3, 1'b0, 3);
    wait_idle("t2_1to14");
    run_req(4'd3, 4'd14, 5, 1'b1, 5);
    wait_idle("14to3");
    run_req(4'd3, 4'd3, 0, 1'b1, 0);
`else
    run_req(4'd14, 4'd1, 13, 1'b1, 13);
    wait_idle("t2_1to14");
    run_req(4'd3, 4'd14, 11, 1'b0, 11);
    wait_idle("14to3");
    run_req(4'd3, 4'd3, 0, 1'b0, 0);
`endif
    wait_idle("t4_same");
    run_req(4'd0, 4'd3, 3, 1'b0, 3);
    wait_idle("3to0");
    run_req(4'd8, 4'd0, 8, 1'b1, 8);
    wait_idle("t3_0to8");
`ifdef COUNTER_SEQ_CTRL_WRAP_EN
    run_req(4'd0, 4'd8, 8, 1'b1, 8);
`else
    run_req(4'd0, 4'd8, 8, 1'b0, 8);
`endif
    wait_idle("8to0");

    // abort mid-run once dout reaches 3
    run_req(4'd5, 4'd0, 5, 1'b1, 3);
    k = 0;
    while (bus.dout !== 4'd3 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("t5_reach3", bus.dout, 3);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    chk("t5_ready", bus.req_ready, 1);
    chk("t5_busy", bus.busy, 0);
    chk("t5_dout", bus.dout, 3);
    chk("t5_done", bus.done, 0);
    run_req(4'd2, 4'd3, 1, 1'b0, 1);
    wait_idle("t5_after");

    // async reset mid-run
    run_req(4'd9, 4'd2, 7, 1'b1, 7);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t6_dout", bus.dout, 0);
    chk("t6_busy", bus.busy, 0);
    chk("t6_done", bus.done, 0);
    chk("t6_ready", bus.req_ready, 1);
    chk("t6_up", bus.up, 0);
    q.delete();
    @(negedge clk);
    #2 rst = 1'b1;
    run_req(4'd2, 4'd0, 2, 1'b1, 2);
    wait_idle("t6_after");

    repeat (4) @(negedge clk);
    chk("no_leftover", q.size(), 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
